// File: rtl/bus_mem_pkg.sv
// rtl/bus_mem_pkg.sv - shared types, defaults and byte-merge helper for bus_wait_mem
// Contents:
//   state_t           : transfer FSM states (IDLE, WAIT, ACK)
//   DEFAULT_BASE_ADDR : MIPS reset vector, the byte address of word 0
//   be_merge()        : byte-enable merge of a write into an existing word

package bus_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC00000;

    // An all-zero byteenable means a full-word store. The CPU's sw path
    // leaves byteenable at 0, so 4'b0000 is widened to 4'b1111 here.
    function automatic logic [31:0] be_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [3:0]  be
    );
        logic [3:0]  eff_be;
        logic [31:0] merged;
        eff_be = (be == 4'b0000) ? 4'b1111 : be;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (eff_be[b]) begin
                merged[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/bus_wait_mem.sv
// rtl/bus_wait_mem.sv - word RAM slave with fixed wait states on an Avalon-style bus
// Ports:
//   clk, reset        : clock; asynchronous active-low reset
//   address           : byte address from the master
//   read, write       : requests, held until waitrequest is low
//   writedata         : write data
//   byteenable        : per-byte write enables (0000 means full word)
//   waitrequest       : high while the current transfer is not accepted
//   readdata          : registered read data, loaded on entry to ACK
//   error             : high for the ACK cycle of an illegal access
//   init_we/addr/data : backdoor full-word write, highest priority

module bus_wait_mem
    import bus_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 2,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   address,
    input  logic          read,
    input  logic          write,
    input  logic [31:0]   writedata,
    input  logic [3:0]    byteenable,
    output logic          waitrequest,
    output logic [31:0]   readdata,
    output logic          error,
    input  logic          init_we,
    input  logic [AW-1:0] init_addr,
    input  logic [31:0]   init_data
);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   readdata_q, readdata_d;
    logic          error_q, error_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          req;
    logic [31:0]   word_idx_full;
    logic [AW-1:0] idx;
    logic          addr_ok;
    logic          idle_read;
    logic          illegal;
    logic          enter_ack;
    logic          bus_we;
    logic [31:0]   bus_wdata;

    // Address decode. Addresses below BASE_ADDR wrap to huge indices, but
    // the explicit lower-bound compare rejects them regardless.
    always_comb begin
        req           = read | write;
        word_idx_full = (address - BASE_ADDR) >> 2;
        idx           = word_idx_full[AW-1:0];
        addr_ok       = (address[1:0] == 2'b00) && (address >= BASE_ADDR)
                        && (word_idx_full < 32'(DEPTH_WORDS));
        // The CPU parks on address 0 when idle; such reads are benign.
        idle_read     = read && !write && (address == 32'd0);
        illegal       = !(addr_ok || idle_read) || (read && write);
    end

    // FSM next state, wait counter and registered outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        readdata_d = readdata_q;
        error_d    = 1'b0;
        enter_ack  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    cnt_d = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d   = ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    // Master withdrew the request: abandon quietly.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d   = ACK;
                        enter_ack = 1'b1;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_ack) begin
            error_d = illegal;
            if (read) begin
                readdata_d = (illegal || idle_read) ? 32'd0 : mem_q[idx];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            readdata_q <= 32'd0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            error_q    <= error_d;
        end
    end

    // Writes commit on the edge leaving ACK. A simultaneous read does not
    // block the write as long as the address itself is valid. Reset forces
    // the state out of ACK asynchronously, which drops an in-flight write.
    always_comb begin
        bus_we    = (state_q == ACK) && write && addr_ok;
        bus_wdata = be_merge(mem_q[idx], writedata, byteenable);
    end

    // The backdoor write is issued last so it wins on a same-index collision.
    always_ff @(posedge clk) begin
        if (bus_we) begin
            mem_q[idx] <= bus_wdata;
        end
        if (init_we) begin
            mem_q[init_addr] <= init_data;
        end
    end

    assign waitrequest = req && (state_q != ACK);
    assign readdata    = readdata_q;
    assign error       = error_q;

endmodule

// File: tb/tb_bus_wait_mem.sv
// tb/tb_bus_wait_mem.sv - scoreboard bench for bus_wait_mem (WAIT_CYCLES=2 and 0)

module tb_bus_wait_mem;

    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          DEPTH = 64;
    localparam int          WC    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] address, writedata, readdata;
    logic        read, write, waitrequest, error;
    logic [3:0]  byteenable;
    logic        init_we;
    logic [5:0]  init_addr;
    logic [31:0] init_data;

    logic [31:0] address_z, readdata_z, init_data_z;
    logic        read_z, waitrequest_z, error_z, init_we_z;
    logic [5:0]  init_addr_z;

    always #5 clk = ~clk;

    bus_wait_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) u_dut (
        .clk(clk), .reset(rst_n), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .error(error), .init_we(init_we), .init_addr(init_addr),
        .init_data(init_data)
    );

    bus_wait_mem #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_z (
        .clk(clk), .reset(rst_n), .address(address_z), .read(read_z), .write(1'b0),
        .writedata(32'd0), .byteenable(4'b0000), .waitrequest(waitrequest_z),
        .readdata(readdata_z), .error(error_z), .init_we(init_we_z), .init_addr(init_addr_z),
        .init_data(init_data_z)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_z   [DEPTH];
    logic [31:0] last_rd;
    int          total = 0;
    int          bad   = 0;

    bit          collide = 1'b0;
    logic [5:0]  coll_idx;
    logic [31:0] coll_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit addr_legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
    endfunction

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge clk);
        init_we = 1'b1; init_addr = 6'(idx); init_data = data;
        @(negedge clk);
        init_we = 1'b0;
        model_mem[idx] = data;
    endtask

    task automatic xfer(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        exp_t        e;
        int          stall;
        logic [31:0] w;
        int          idx;
        idx   = int'((a - BASE) >> 2);
        e.err = !(addr_legal(a) || (rd && !wr && a == 32'd0)) || (rd && wr);
        if (rd) begin
            e.data  = (e.err || a == 32'd0) ? 32'd0 : model_mem[idx];
            last_rd = e.data;
        end else begin
            e.data = last_rd;
        end
        sb.push_back(e);
        if (wr && addr_legal(a)) begin
            w = model_mem[idx];
            for (int b = 0; b < 4; b++)
                if (be == 4'b0000 || be[b]) w[8*b +: 8] = wd[8*b +: 8];
            model_mem[idx] = w;
        end

        @(negedge clk);
        address = a; read = rd; write = wr; writedata = wd; byteenable = be;
        stall = 0;
        #1;
        while (waitrequest && stall < 40) begin
            stall++;
            @(negedge clk);
            #1;
        end
        if (waitrequest) chk("ack_timeout", waitrequest, 0);
        chk("stall_cycles", stall, WC + 1);
        e = sb.pop_front();
        chk("readdata", readdata, e.data);
        chk("error", error, e.err);
        if (collide) begin
            init_we = 1'b1; init_addr = coll_idx; init_data = coll_data;
            model_mem[coll_idx] = coll_data;
        end
        @(negedge clk);
        read = 1'b0; write = 1'b0; init_we = 1'b0; collide = 1'b0;
        #1;
        chk("error_clear", error, 0);
        chk("readdata_hold", readdata, last_rd);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        exp_t e;
        rst_n = 1'b0; address = 32'd0; read = 1'b0; write = 1'b0;
        writedata = 32'd0; byteenable = 4'b0000;
        init_we = 1'b0; init_addr = 6'd0; init_data = 32'd0;
        address_z = 32'd0; read_z = 1'b0; init_we_z = 1'b0;
        init_addr_z = 6'd0; init_data_z = 32'd0;
        last_rd = 32'd0;

        // Reset state; waitrequest follows the request during reset.
        @(negedge clk); #1;
        chk("rst_readdata", readdata, 0);
        chk("rst_error", error, 0);
        chk("rst_waitreq_idle", waitrequest, 0);
        read = 1'b1; #1;
        chk("rst_waitreq_req", waitrequest, 1);
        read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        preload(0, 32'h8D090018);
        preload(6, 32'd111);
        preload(7, 32'hAABBCCDD);
        preload(5, 32'hCAFEF00D);
        preload(9, 32'h00000000);

        xfer(1, 0, 32'hBFC00018, 32'd0, 4'h0);
        chk("word6_value", readdata, 32'h6F);

        xfer(0, 1, 32'hBFC0001C, 32'h11223344, 4'b0011);
        xfer(1, 0, 32'hBFC0001C, 32'd0, 4'h0);
        chk("be_merge_value", readdata, 32'hAABB3344);

        xfer(0, 1, 32'hBFC0000C, 32'hDEADBEEF, 4'b0000);
        xfer(1, 0, 32'hBFC0000C, 32'd0, 4'h0);

        xfer(1, 0, 32'hBFC00001, 32'd0, 4'h0);
        xfer(1, 0, BASE + 32'(4 * DEPTH), 32'd0, 4'h0);
        xfer(1, 0, 32'h00001000, 32'd0, 4'h0);
        xfer(1, 0, 32'h00000000, 32'd0, 4'h0);
        xfer(0, 1, BASE + 32'(4 * DEPTH), 32'h0BADF00D, 4'hF);
        xfer(1, 0, 32'hBFC00000, 32'd0, 4'h0);

        // Read and write together: write lands, error pulses, readdata 0.
        xfer(1, 1, 32'hBFC00020, 32'h12345678, 4'hF);
        xfer(1, 0, 32'hBFC00020, 32'd0, 4'h0);

        // Backdoor write on the same edge as a bus write to the same word.
        collide = 1'b1; coll_idx = 6'd9; coll_data = 32'h55AA55AA;
        xfer(0, 1, 32'hBFC00024, 32'h01010101, 4'hF);
        xfer(1, 0, 32'hBFC00024, 32'd0, 4'h0);

        // Abort during WAIT: no ACK, readdata untouched, FSM back in IDLE.
        @(negedge clk);
        address = 32'hBFC00018; read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        read = 1'b0; #1;
        chk("abort_waitreq", waitrequest, 0);
        @(negedge clk); #1;
        chk("abort_readdata", readdata, last_rd);
        chk("abort_error", error, 0);
        xfer(1, 0, 32'hBFC00000, 32'd0, 4'h0);

        // Reset asserted during the ACK of a write: the write is discarded.
        @(negedge clk);
        address = 32'hBFC00014; write = 1'b1; writedata = 32'h0; byteenable = 4'hF;
        n = 0; #1;
        while (waitrequest && n < 40) begin
            n++;
            @(negedge clk); #1;
        end
        if (waitrequest) chk("ack_timeout_rst", waitrequest, 0);
        rst_n = 1'b0; #1;
        chk("midrst_readdata", readdata, 0);
        chk("midrst_error", error, 0);
        chk("midrst_waitreq", waitrequest, 1);
        @(negedge clk);
        write = 1'b0; rst_n = 1'b1; last_rd = 32'd0;
        xfer(1, 0, 32'hBFC00014, 32'd0, 4'h0);
        chk("midrst_word5", readdata, 32'hCAFEF00D);

        // Zero wait states, back-to-back reads: ACK every second cycle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            init_we_z = 1'b1; init_addr_z = 6'(i); init_data_z = 32'hA5000000 + 32'(i * 17);
            model_z[i] = init_data_z;
        end
        @(negedge clk);
        init_we_z = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e.data = model_z[i]; e.err = 1'b0;
            sb.push_back(e);
        end
        address_z = BASE; read_z = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("b2b_stall", waitrequest_z, 1);
            @(negedge clk); #1;
            chk("b2b_ack", waitrequest_z, 0);
            e = sb.pop_front();
            chk("b2b_readdata", readdata_z, e.data);
            chk("b2b_error", error_z, e.err);
            address_z = BASE + 32'(4 * (i + 1));
            @(negedge clk);
        end
        read_z = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
